scanline_reader: RTL and testbench



---
 rtl/scanline_reader.sv | 188 ++++++++++++++++++
 tb/tb_scanline_reader.sv | 138 +++++++++++++
 2 files changed

// File: rtl/scanline_reader.sv
// scanline_reader
//   Raster timing generator and line-buffer reader. Walks every frame line
//   through HSYNC/BACK/ACTIVE/FRONT, fetches the stored image line from the
//   BRAM read port, and serialises its pixels LSB first at one pixel per
//   CLKS_PER_PIXEL clocks.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   enable          run request, sampled only at line boundaries
//   bram_addr_rd    BRAM read address (BRAM has 1-clock registered read)
//   bram_data_rd    BRAM read data, pixel i = bit i
//   pixel_out       current pixel bit (0 outside ACTIVE and on sync lines)
//   pixel_valid     high during ACTIVE of image lines
//   hsync           high during HSYNC
//   vsync           high for the whole of each sync line
//   frame_start     one-clock pulse on entering HSYNC of frame line 0
//   line_idx        current frame line
module scanline_reader #(
   parameter int PIXELS         = 300,
   parameter int LINES          = 608,
   parameter int DATA_W         = 400,
   parameter int ADDR_W         = 10,
   parameter int CLKS_PER_PIXEL = 5,
   parameter int HSYNC_CLKS     = 24,
   parameter int HBACK_CLKS     = 48,
   parameter int HFRONT_CLKS    = 16,
   parameter int VSYNC_LINES    = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   output logic [ADDR_W-1:0] bram_addr_rd,
   input  logic [DATA_W-1:0] bram_data_rd,
   output logic              pixel_out,
   output logic              pixel_valid,
   output logic              hsync,
   output logic              vsync,
   output logic              frame_start,
   output logic [ADDR_W-1:0] line_idx
);

   localparam int ACT_CLKS    = PIXELS * CLKS_PER_PIXEL;
   localparam int FRAME_LINES = VSYNC_LINES + LINES;
   localparam int MAX_A       = (HSYNC_CLKS > HBACK_CLKS) ? HSYNC_CLKS : HBACK_CLKS;
   localparam int MAX_B       = (ACT_CLKS > HFRONT_CLKS) ? ACT_CLKS : HFRONT_CLKS;
   localparam int CNT_MAX     = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W       = $clog2(CNT_MAX + 1);
   localparam int DIV_W       = $clog2(CLKS_PER_PIXEL + 1);

   typedef enum logic [2:0] {IDLE, HSYNC, BACK, ACTIVE, FRONT} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   line_q, line_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [PIXELS-1:0]   shreg_q, shreg_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic                hsync_q, hsync_d;
   logic                vsync_q, vsync_d;
   logic                pv_q, pv_d;
   logic                po_q, po_d;
   logic                fs_q, fs_d;

   logic                last_clk;
   logic                image_q, image_d;
   logic                enter_hsync;
   logic                unused_data;

   assign last_clk    = (cnt_q == '0);
   assign image_q     = (line_q >= ADDR_W'(VSYNC_LINES));
   assign image_d     = (line_d >= ADDR_W'(VSYNC_LINES));
   assign enter_hsync = (state_d == HSYNC) && (state_q != HSYNC);
   // Bits above PIXELS are never displayed.
   assign unused_data = ^bram_data_rd;

   // State register (with all datapath and output flops)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         line_q  <= '0;
         addr_q  <= '0;
         shreg_q <= '0;
         div_q   <= '0;
         hsync_q <= 1'b0;
         vsync_q <= 1'b0;
         pv_q    <= 1'b0;
         po_q    <= 1'b0;
         fs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         line_q  <= line_d;
         addr_q  <= addr_d;
         shreg_q <= shreg_d;
         div_q   <= div_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         pv_q    <= pv_d;
         po_q    <= po_d;
         fs_q    <= fs_d;
      end
   end

   // Next-state: each state's down-counter is loaded on entry and the state
   // is left on the clock where it reads zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      line_d  = line_q;
      if (state_q != IDLE && !last_clk) cnt_d = cnt_q - 1'b1;
      case (state_q)
         IDLE: if (enable) begin
            state_d = HSYNC;
            cnt_d   = CNT_W'(HSYNC_CLKS - 1);
            line_d  = '0;
         end
         HSYNC: if (last_clk) begin
            state_d = BACK;
            cnt_d   = CNT_W'(HBACK_CLKS - 1);
         end
         BACK: if (last_clk) begin
            state_d = ACTIVE;
            cnt_d   = CNT_W'(ACT_CLKS - 1);
         end
         ACTIVE: if (last_clk) begin
            state_d = FRONT;
            cnt_d   = CNT_W'(HFRONT_CLKS - 1);
         end
         FRONT: if (last_clk) begin
            if (!enable) begin
               state_d = IDLE;
               cnt_d   = '0;
               line_d  = '0;
            end else begin
               state_d = HSYNC;
               cnt_d   = CNT_W'(HSYNC_CLKS - 1);
               line_d  = (line_q == ADDR_W'(FRAME_LINES - 1)) ? '0 : line_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            line_d  = '0;
         end
      endcase
   end

   // Outputs and datapath, all computed from the next state so every
   // output is a flop aligned with the state it belongs to.
   always_comb begin
      addr_d  = addr_q;
      shreg_d = shreg_q;
      div_d   = div_q;
      if (state_d == IDLE)
         addr_d = '0;
      else if (enter_hsync && image_d)
         addr_d = line_d - ADDR_W'(VSYNC_LINES);

      // Capture on the last BACK clock; the address has been stable since
      // HSYNC entry so the registered BRAM output is settled.
      if (state_q == BACK && last_clk) begin
         shreg_d = image_q ? bram_data_rd[PIXELS-1:0] : '0;
         div_d   = DIV_W'(CLKS_PER_PIXEL - 1);
      end else if (state_q == ACTIVE) begin
         if (div_q == '0) begin
            shreg_d = shreg_q >> 1;
            div_d   = DIV_W'(CLKS_PER_PIXEL - 1);
         end else begin
            div_d = div_q - 1'b1;
         end
      end

      hsync_d = (state_d == HSYNC);
      vsync_d = (state_d != IDLE) && !image_d;
      pv_d    = (state_d == ACTIVE) && image_d;
      po_d    = pv_d && shreg_d[0];
      fs_d    = enter_hsync && (line_d == '0);
   end

   assign bram_addr_rd = addr_q;
   assign pixel_out    = po_q;
   assign pixel_valid  = pv_q;
   assign hsync        = hsync_q;
   assign vsync        = vsync_q;
   assign frame_start  = fs_q;
   assign line_idx     = line_q;

endmodule

// File: tb/tb_scanline_reader.sv
// Directed bench for scanline_reader with small raster parameters:
// line = 3+2+16+2 = 23 clocks, frame = 6 lines = 138 clocks.
// Expected outputs come from a timeline model indexed by clocks since the
// frame's first HSYNC clock.
module tb_scanline_reader;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic [3:0]  bram_addr_rd;
   logic [11:0] bram_data_rd;
   logic        pixel_out, pixel_valid, hsync, vsync, frame_start;
   logic [3:0]  line_idx;

   logic [11:0] mem [4];
   logic [7:0]  img [4];
   int          n_assert;
   int          n_fail;
   logic [12:0] dut_vec;

   scanline_reader #(
      .PIXELS(8), .LINES(4), .DATA_W(12), .ADDR_W(4), .CLKS_PER_PIXEL(2),
      .HSYNC_CLKS(3), .HBACK_CLKS(2), .HFRONT_CLKS(2), .VSYNC_LINES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .bram_addr_rd(bram_addr_rd), .bram_data_rd(bram_data_rd),
      .pixel_out(pixel_out), .pixel_valid(pixel_valid), .hsync(hsync),
      .vsync(vsync), .frame_start(frame_start), .line_idx(line_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // BRAM with 1-clock registered read
   always @(posedge clk) bram_data_rd <= mem[bram_addr_rd[1:0]];

   assign dut_vec = {frame_start, hsync, vsync, pixel_valid, pixel_out, line_idx, bram_addr_rd};

   // {fs, hs, vs, pv, po, line_idx[3:0], addr[3:0]}; sa = address on sync lines
   function automatic logic [12:0] model(input int t, input logic [3:0] sa);
      int ln, pos;
      logic fs, hs, vs, pv, po;
      logic [3:0] li, ad;
      logic [7:0] row;
      ln  = t / 23;
      pos = t % 23;
      fs  = (t == 0);
      hs  = (pos < 3);
      vs  = (ln < 2);
      pv  = (ln >= 2) && (pos >= 5) && (pos < 21);
      po  = 1'b0;
      if (pv) begin
         row = img[ln-2];
         po  = row[(pos-5)/2];
      end
      li = 4'(ln);
      ad = (ln >= 2) ? 4'(ln - 2) : sa;
      return {fs, hs, vs, pv, po, li, ad};
   endfunction

   task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      enable   = 1'b0;
      mem[0] = 12'h0A5; mem[1] = 12'h3C3; mem[2] = 12'h00F; mem[3] = 12'hF81;
      img[0] = 8'hA5;   img[1] = 8'hC3;   img[2] = 8'h0F;   img[3] = 8'h81;

      // Reset, then idle with enable low
      repeat (3) @(posedge clk);
      #1;
      chk("reset", dut_vec, 13'h0);
      @(negedge clk) rst_n = 1'b1;
      step();
      for (int i = 0; i < 200; i++) begin
         chk("idle", dut_vec, 13'h0);
         step();
      end

      // Two continuous frames; BRAM line 0 overwritten mid-ACTIVE in frame 2
      enable = 1'b1;
      step();
      for (int t = 0; t < 276; t++) begin
         if (t == 138 + 46 + 10) mem[0] = 12'h000;
         if (t == 138 + 46 + 22) mem[0] = 12'h0A5;
         chk("run", dut_vec, model(t % 138, (t < 138) ? 4'd0 : 4'd3));
         step();
      end

      // Third frame: drop enable on clock 8 of image line 1
      for (int t = 0; t < 92; t++) begin
         if (t == 69 + 8) enable = 1'b0;
         chk("disable", dut_vec, model(t, 4'd3));
         step();
      end
      for (int i = 0; i < 10; i++) begin
         chk("post_disable_idle", dut_vec, 13'h0);
         step();
      end

      // Re-enable: restarts at line 0 one clock later
      enable = 1'b1;
      step();
      for (int t = 0; t < 56; t++) begin
         chk("reenable", dut_vec, model(t, 4'd0));
         step();
      end

      // Async reset pulse mid-ACTIVE of image line 0
      #2 rst_n = 1'b0;
      #1 chk("async_rst", dut_vec, 13'h0);
      @(posedge clk);
      #3 chk("rst_hold", dut_vec, 13'h0);
      rst_n = 1'b1;
      step();
      for (int t = 0; t < 138; t++) begin
         chk("after_rst", dut_vec, model(t, 4'd0));
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
